// File: rtl/id_pipe_stage.sv
// MIPS instruction-decode stage: register file with optional same-cycle write bypass,
// immediate extension, load-use hazard detection and the ID/EX register.
module id_pipe_stage #(
  parameter int DW     = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          If_valid,
  input  logic [31:0]   Ins,
  output logic          Id_ready,
  input  logic          We,
  input  logic [AW-1:0] Waddr,
  input  logic [DW-1:0] Wdata,
  input  logic          Ex_load,
  input  logic [AW-1:0] Ex_rt,
  input  logic          Ex_ready,
  input  logic          Flush,
  output logic          Id_valid,
  output logic [31:0]   Ins_q,
  output logic [DW-1:0] Rdata1,
  output logic [DW-1:0] Rdata2,
  output logic [DW-1:0] Ed32
);

  logic [DW-1:0] regs [NREG];

  logic [5:0]    op;
  logic [AW-1:0] rs_a, rt_a;
  logic [15:0]   imm;
  logic          wr_en, uses_rt, hazard, adv;
  logic [DW-1:0] rd1_c, rd2_c, ext_c;

  assign op   = Ins[31:26];
  assign rs_a = AW'(Ins[25:21]);
  assign rt_a = AW'(Ins[20:16]);
  assign imm  = Ins[15:0];

  // Writes to reg 0 or past the implemented registers are dropped.
  assign wr_en = We && (Waddr != '0) && (32'(Waddr) < NREG);

  function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = '0;
    if (a != '0 && 32'(a) < NREG) begin
      if (BYPASS && wr_en && Waddr == a) v = Wdata;
      else                               v = regs[a];
    end
    return v;
  endfunction

  always_comb begin
    rd1_c = rf_read(rs_a);
    rd2_c = rf_read(rt_a);
  end

  always_comb begin
    ext_c = DW'(signed'(imm));
    case (op)
      6'h0C, 6'h0D, 6'h0E: ext_c = DW'(imm);
      6'h0F:               ext_c = DW'({imm, 16'h0000});
      default:             ext_c = DW'(signed'(imm));
    endcase
  end

  // A load in EX whose destination this instruction reads must wait one cycle.
  assign uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
  assign hazard  = If_valid && Ex_load && (Ex_rt != '0) &&
                   ((Ex_rt == rs_a) || (uses_rt && (Ex_rt == rt_a)));

  // Valid/ready: Ins moves IF->ID on a cycle with If_valid && Id_ready, and the
  // ID/EX contents move to EX on a cycle with Id_valid && Ex_ready. While Id_valid
  // is high and Ex_ready is low, every ID/EX output stays stable apart from
  // operand refresh by write-back to the same register.
  assign adv      = Ex_ready || !Id_valid;
  assign Id_ready = Flush || (adv && !hazard);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[Waddr] <= Wdata;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Id_valid <= 1'b0;
      Ins_q    <= '0;
      Rdata1   <= '0;
      Rdata2   <= '0;
      Ed32     <= '0;
    end else if (Flush) begin
      Id_valid <= 1'b0;
    end else if (adv && hazard) begin
      Id_valid <= 1'b0;
    end else if (adv) begin
      Id_valid <= If_valid;
      Ins_q    <= Ins;
      Rdata1   <= rd1_c;
      Rdata2   <= rd2_c;
      Ed32     <= ext_c;
    end else begin
      // Held operands track write-back so EX sees current values when it resumes.
      if (We && Waddr != '0 && Waddr == AW'(Ins_q[25:21])) Rdata1 <= Wdata;
      if (We && Waddr != '0 && Waddr == AW'(Ins_q[20:16])) Rdata2 <= Wdata;
    end
  end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Bench for id_pipe_stage: two instances (32-bit/bypass, 64-bit/no-bypass/24 regs)
// driven identically and compared against an architectural reference model.
module tb_id_pipe_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_valid, we, ex_load, ex_ready, flush;
  logic [31:0] ins;
  logic [4:0]  waddr, ex_rt;
  logic [63:0] wdata;

  logic        rdy_a, val_a, rdy_b, val_b;
  logic [31:0] insq_a, insq_b, rd1_a, rd2_a, ed_a;
  logic [63:0] rd1_b, rd2_b, ed_b;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  id_pipe_stage #(.DW(32), .NREG(32), .AW(5), .BYPASS(1'b1)) u_a (
    .CLK(CLK), .RST(RST), .If_valid(if_valid), .Ins(ins), .Id_ready(rdy_a),
    .We(we), .Waddr(waddr), .Wdata(wdata[31:0]), .Ex_load(ex_load), .Ex_rt(ex_rt),
    .Ex_ready(ex_ready), .Flush(flush), .Id_valid(val_a), .Ins_q(insq_a),
    .Rdata1(rd1_a), .Rdata2(rd2_a), .Ed32(ed_a));

  id_pipe_stage #(.DW(64), .NREG(24), .AW(5), .BYPASS(1'b0)) u_b (
    .CLK(CLK), .RST(RST), .If_valid(if_valid), .Ins(ins), .Id_ready(rdy_b),
    .We(we), .Waddr(waddr), .Wdata(wdata), .Ex_load(ex_load), .Ex_rt(ex_rt),
    .Ex_ready(ex_ready), .Flush(flush), .Id_valid(val_b), .Ins_q(insq_b),
    .Rdata1(rd1_b), .Rdata2(rd2_b), .Ed32(ed_b));

  // Reference model: index 0 = instance A, 1 = instance B.
  int          m_dw   [2] = '{32, 64};
  int          m_nreg [2] = '{32, 24};
  bit          m_byp  [2] = '{1'b1, 1'b0};
  logic [63:0] m_mem  [2][32];
  logic [31:0] m_ins  [2];
  logic [63:0] m_rd1 [2], m_rd2 [2], m_ed [2];
  bit          m_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int k);
    return (m_dw[k] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] m_read(input int k, input int a);
    if (a == 0 || a >= m_nreg[k]) return 64'h0;
    if (m_byp[k] && we && int'(waddr) == a) return wdata & mask(k);
    return m_mem[k][a];
  endfunction

  function automatic logic [63:0] m_ext(input int k, input logic [31:0] i);
    logic [15:0] im;
    im = i[15:0];
    case (i[31:26])
      6'h0C, 6'h0D, 6'h0E: return {48'h0, im};
      6'h0F:               return {32'h0, im, 16'h0};
      default:             return {{48{im[15]}}, im} & mask(k);
    endcase
  endfunction

  function automatic bit m_hazard();
    bit rt_used;
    rt_used = ins[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2B};
    return if_valid && ex_load && ex_rt != 0 &&
           (ex_rt == ins[25:21] || (rt_used && ex_rt == ins[20:16]));
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) m_mem[k][r] = 64'h0;
      m_ins[k] = '0; m_rd1[k] = '0; m_rd2[k] = '0; m_ed[k] = '0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid_a"}, {63'h0, val_a}, {63'h0, m_valid});
    chk({tag, "_valid_b"}, {63'h0, val_b}, {63'h0, m_valid});
    if (m_valid) begin
      chk({tag, "_insq_a"}, {32'h0, insq_a}, {32'h0, m_ins[0]});
      chk({tag, "_insq_b"}, {32'h0, insq_b}, {32'h0, m_ins[1]});
      chk({tag, "_rd1_a"},  {32'h0, rd1_a},  m_rd1[0]);
      chk({tag, "_rd2_a"},  {32'h0, rd2_a},  m_rd2[0]);
      chk({tag, "_ed_a"},   {32'h0, ed_a},   m_ed[0]);
      chk({tag, "_rd1_b"},  rd1_b,           m_rd1[1]);
      chk({tag, "_rd2_b"},  rd2_b,           m_rd2[1]);
      chk({tag, "_ed_b"},   ed_b,            m_ed[1]);
    end
  endtask

  // Inputs are already driven; check Id_ready, clock once, then check ID/EX.
  task automatic cycle(input string tag);
    bit haz, adv, exp_rdy, n_valid;
    logic [31:0] n_ins [2];
    logic [63:0] n_rd1 [2], n_rd2 [2], n_ed [2];
    #1;
    haz     = m_hazard();
    adv     = ex_ready || !m_valid;
    exp_rdy = flush || (adv && !haz);
    chk({tag, "_ready_a"}, {63'h0, rdy_a}, {63'h0, exp_rdy});
    chk({tag, "_ready_b"}, {63'h0, rdy_b}, {63'h0, exp_rdy});
    n_valid = m_valid;
    for (int k = 0; k < 2; k++) begin
      n_ins[k] = m_ins[k]; n_rd1[k] = m_rd1[k]; n_rd2[k] = m_rd2[k]; n_ed[k] = m_ed[k];
      if (flush || (adv && haz)) begin
        n_valid = 1'b0;
      end else if (adv) begin
        n_valid  = if_valid;
        n_ins[k] = ins;
        n_rd1[k] = m_read(k, int'(ins[25:21]));
        n_rd2[k] = m_read(k, int'(ins[20:16]));
        n_ed[k]  = m_ext(k, ins);
      end else if (we && waddr != 0) begin
        if (waddr == m_ins[k][25:21]) n_rd1[k] = wdata & mask(k);
        if (waddr == m_ins[k][20:16]) n_rd2[k] = wdata & mask(k);
      end
    end
    @(posedge CLK);
    m_valid = n_valid;
    for (int k = 0; k < 2; k++) begin
      m_ins[k] = n_ins[k]; m_rd1[k] = n_rd1[k]; m_rd2[k] = n_rd2[k]; m_ed[k] = n_ed[k];
      if (we && waddr != 0 && int'(waddr) < m_nreg[k]) m_mem[k][waddr] = wdata & mask(k);
    end
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  task automatic idle();
    if_valid = 0; ins = '0; we = 0; waddr = '0; wdata = '0;
    ex_load = 0; ex_rt = '0; ex_ready = 1; flush = 0;
  endtask

  initial begin
    logic [5:0] ops [10] = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23};

    RST = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_outputs("reset");
    chk("reset_insq_a", {32'h0, insq_a}, 64'h0);
    chk("reset_rd1_b", rd1_b, 64'h0);
    chk("reset_ed_b", ed_b, 64'h0);
    RST = 1'b1;

    // Write then read back through rs.
    we = 1; waddr = 5'd9; wdata = 64'h0000_00AB_0000_1234;
    cycle("t1w");
    idle(); if_valid = 1; ins = mk(6'h00, 5'd9, 5'd0, 16'h0820);
    cycle("t1r");
    chk("t1_rd1_a", {32'h0, rd1_a}, 64'h1234);
    chk("t1_rd2_a", {32'h0, rd2_a}, 64'h0);
    chk("t1_rd1_b", rd1_b, 64'h0000_00AB_0000_1234);
    chk("t1_valid", {63'h0, val_a}, 64'h1);

    // Same-cycle write: bypassed on A, old value on B.
    idle(); we = 1; waddr = 5'd10; wdata = 64'd5; if_valid = 1; ins = mk(6'h00, 5'd10, 5'd0, 16'h0);
    cycle("t2");
    chk("t2_byp_a", {32'h0, rd1_a}, 64'd5);
    chk("t2_nobyp_b", rd1_b, 64'd0);

    // Reg 0 ignores writes.
    idle(); we = 1; waddr = 5'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle("t3w");
    idle(); if_valid = 1; ins = mk(6'h00, 5'd0, 5'd0, 16'h0);
    cycle("t3r");
    chk("t3_r0_a", {32'h0, rd1_a}, 64'h0);
    chk("t3_r0_b", rd1_b, 64'h0);

    // Load-use stall on rt, no stall when rt is only a destination.
    idle(); ex_load = 1; ex_rt = 5'd11; if_valid = 1; ins = mk(6'h00, 5'd1, 5'd11, 16'h0);
    cycle("t4s");
    chk("t4_bubble", {63'h0, val_a}, 64'h0);
    idle(); ex_load = 1; ex_rt = 5'd11; if_valid = 1; ins = mk(6'h08, 5'd1, 5'd11, 16'h0004);
    cycle("t4n");
    chk("t4_nostall", {63'h0, val_a}, 64'h1);

    // EX stall with write-back to a held operand, then flush.
    idle(); if_valid = 1; ins = mk(6'h00, 5'd12, 5'd13, 16'h0);
    cycle("t5l");
    idle(); ex_ready = 0; if_valid = 1; ins = mk(6'h08, 5'd2, 5'd3, 16'h0);
    we = 1; waddr = 5'd12; wdata = 64'd7;
    cycle("t5h");
    chk("t5_rd1_a", {32'h0, rd1_a}, 64'd7);
    chk("t5_rd1_b", rd1_b, 64'd7);
    chk("t5_held_insq", {32'h0, insq_a}, {32'h0, mk(6'h00, 5'd12, 5'd13, 16'h0)});
    idle(); ex_ready = 0; flush = 1; if_valid = 1; ins = mk(6'h08, 5'd2, 5'd3, 16'h0);
    cycle("t5f");
    chk("t5_flush", {63'h0, val_b}, 64'h0);

    // Immediate extension at both widths.
    idle(); if_valid = 1; ins = mk(6'h08, 5'd0, 5'd1, 16'h8001);
    cycle("t6a");
    chk("t6_addi_a", {32'h0, ed_a}, 64'hFFFF_8001);
    chk("t6_addi_b", ed_b, 64'hFFFF_FFFF_FFFF_8001);
    idle(); if_valid = 1; ins = mk(6'h0D, 5'd0, 5'd1, 16'h8001);
    cycle("t6o");
    chk("t6_ori_a", {32'h0, ed_a}, 64'h8001);
    chk("t6_ori_b", ed_b, 64'h8001);
    idle(); if_valid = 1; ins = mk(6'h0F, 5'd0, 5'd1, 16'h8001);
    cycle("t6l");
    chk("t6_lui_a", {32'h0, ed_a}, 64'h8001_0000);
    chk("t6_lui_b", ed_b, 64'h0000_0000_8001_0000);

    // Randomised traffic; addresses up to 27 exercise B's unimplemented registers.
    for (int n = 0; n < 400; n++) begin
      if_valid = ($urandom_range(0, 9) < 8);
      ins      = mk(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 27)),
                    5'($urandom_range(0, 27)), 16'($urandom));
      we       = ($urandom_range(0, 9) < 6);
      waddr    = 5'($urandom_range(0, 27));
      wdata    = {$urandom, $urandom};
      ex_load  = ($urandom_range(0, 9) < 3);
      ex_rt    = 5'($urandom_range(0, 15));
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      cycle("rnd");
    end

    // Asynchronous reset mid-stream.
    idle(); if_valid = 1; ins = mk(6'h00, 5'd3, 5'd4, 16'h0);
    cycle("pre_rst");
    #2 RST = 1'b0;
    model_reset();
    #1;
    check_outputs("mid_rst");
    chk("mid_rst_rd1_a", {32'h0, rd1_a}, 64'h0);
    @(posedge CLK);
    #1 RST = 1'b1;
    idle(); if_valid = 1; ins = mk(6'h00, 5'd3, 5'd4, 16'h0);
    cycle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
